// File: rtl/nexys_starship_fault_sched.sv
// Fault scheduler for the starship repair subsystems: decides when and which
// subsystem breaks, with an LFSR-driven repair combo and a tightening interval.
module nexys_starship_fault_sched #(
    parameter int N_SUB         = 4,
    parameter int GRACE_TICKS   = 8,
    parameter int BASE_INTERVAL = 16,
    parameter int LEVEL_STEP    = 2,
    parameter int MIN_INTERVAL  = 4,
    parameter int LEVEL_TICKS   = 64,
    parameter int MAX_BROKEN    = 2
) (
    input  logic             timer_clk,
    input  logic             Reset,
    input  logic             play_flag,
    input  logic             gameover_ctrl,
    input  logic [N_SUB-1:0] broken,
    output logic [N_SUB-1:0] break_req,
    output logic [3:0]       break_hex,
    output logic [2:0]       level,
    output logic [7:0]       issued_count,
    output logic             q_Idle,
    output logic             q_Grace,
    output logic             q_Armed
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRACE = 2'd1,
        ST_ARMED = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'($countones(v));
    endfunction

    // First non-broken index at or above cand, wrapping; lowest offset wins.
    function automatic logic [1:0] pick_free(input logic [1:0] cand, input logic [3:0] brk);
        logic [1:0] sel;
        logic [1:0] idx;
        sel = cand;
        for (int i = 3; i >= 0; i--) begin
            idx = cand + 2'(i);
            sel = brk[idx] ? sel : idx;
        end
        return sel;
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       play_sync_q, gameover_sync_q;
    logic [3:0]       broken_s1_q, broken_s2_q;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [7:0]       grace_cnt_q, grace_cnt_d;
    logic [7:0]       int_cnt_q, int_cnt_d;
    logic [7:0]       level_cnt_q, level_cnt_d;
    logic [2:0]       level_q, level_d;
    logic [7:0]       issued_q, issued_d;
    logic [N_SUB-1:0] break_req_q, break_req_d;
    logic [3:0]       break_hex_q, break_hex_d;

    logic             play_s, gameover_s;
    logic [3:0]       broken_s;
    logic             eligible_s;
    logic [7:0]       step_prod_s, interval_s;
    logic [1:0]       pick_s;

    assign play_s     = play_sync_q[1];
    assign gameover_s = gameover_sync_q[1];
    assign broken_s   = broken_s2_q;

    // Two-flop synchronizers for the Clk-domain controls
    always_ff @(posedge timer_clk or posedge Reset) begin
        if (Reset) begin
            play_sync_q     <= 2'b00;
            gameover_sync_q <= 2'b00;
            broken_s1_q     <= 4'b0000;
            broken_s2_q     <= 4'b0000;
        end else begin
            play_sync_q     <= {play_sync_q[0], play_flag};
            gameover_sync_q <= {gameover_sync_q[0], gameover_ctrl};
            broken_s1_q     <= broken;
            broken_s2_q     <= broken_s1_q;
        end
    end

    // Eligibility, candidate choice and the level-dependent reload interval
    always_comb begin
        eligible_s  = (popcount4(broken_s) < 3'(MAX_BROKEN)) && (broken_s != 4'b1111);
        step_prod_s = 8'(level_q) * 8'(LEVEL_STEP);
        pick_s      = pick_free(lfsr_q[1:0], broken_s);
        if (step_prod_s >= 8'(BASE_INTERVAL - MIN_INTERVAL)) begin
            interval_s = 8'(MIN_INTERVAL);
        end else begin
            interval_s = 8'(BASE_INTERVAL) - step_prod_s;
        end
    end

    // Next-state and datapath for the scheduler FSM
    always_comb begin
        state_d     = state_q;
        lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        grace_cnt_d = grace_cnt_q;
        int_cnt_d   = int_cnt_q;
        level_cnt_d = level_cnt_q;
        level_d     = level_q;
        issued_d    = issued_q;
        break_req_d = {N_SUB{1'b0}};
        break_hex_d = break_hex_q;

        case (state_q)
            ST_IDLE: begin
                grace_cnt_d = 8'd0;
                int_cnt_d   = 8'd0;
                level_cnt_d = 8'd0;
                level_d     = 3'd0;
                issued_d    = 8'd0;
                if (play_s) begin
                    state_d     = ST_GRACE;
                    grace_cnt_d = 8'(GRACE_TICKS);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRACE: begin
                if (gameover_s) begin
                    state_d     = ST_IDLE;
                    grace_cnt_d = 8'd0;
                    int_cnt_d   = 8'd0;
                    level_cnt_d = 8'd0;
                    level_d     = 3'd0;
                    issued_d    = 8'd0;
                end else if (grace_cnt_q == 8'd1) begin
                    state_d     = ST_ARMED;
                    grace_cnt_d = 8'd0;
                    int_cnt_d   = 8'(BASE_INTERVAL);
                    level_cnt_d = 8'd0;
                end else begin
                    grace_cnt_d = grace_cnt_q - 8'd1;
                end
            end
            ST_ARMED: begin
                if (gameover_s) begin
                    state_d     = ST_IDLE;
                    grace_cnt_d = 8'd0;
                    int_cnt_d   = 8'd0;
                    level_cnt_d = 8'd0;
                    level_d     = 3'd0;
                    issued_d    = 8'd0;
                end else begin
                    if (level_cnt_q == 8'(LEVEL_TICKS - 1)) begin
                        level_cnt_d = 8'd0;
                        level_d     = (level_q == 3'd7) ? 3'd7 : level_q + 3'd1;
                    end else begin
                        level_cnt_d = level_cnt_q + 8'd1;
                    end
                    // An expired interval parks at 1 until the subsystems allow a break
                    if ((int_cnt_q == 8'd1) && eligible_s) begin
                        break_req_d = {{(N_SUB-1){1'b0}}, 1'b1} << pick_s;
                        break_hex_d = lfsr_q[7:4];
                        issued_d    = (issued_q == 8'hFF) ? 8'hFF : issued_q + 8'd1;
                        int_cnt_d   = interval_s;
                    end else if (int_cnt_q > 8'd1) begin
                        int_cnt_d = int_cnt_q - 8'd1;
                    end else begin
                        int_cnt_d = 8'd1;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                grace_cnt_d = 8'd0;
                int_cnt_d   = 8'd0;
                level_cnt_d = 8'd0;
                level_d     = 3'd0;
                issued_d    = 8'd0;
            end
        endcase
    end

    // State, LFSR, counters and registered outputs
    always_ff @(posedge timer_clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= LFSR_SEED;
            grace_cnt_q <= 8'd0;
            int_cnt_q   <= 8'd0;
            level_cnt_q <= 8'd0;
            level_q     <= 3'd0;
            issued_q    <= 8'd0;
            break_req_q <= {N_SUB{1'b0}};
            break_hex_q <= 4'h0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            grace_cnt_q <= grace_cnt_d;
            int_cnt_q   <= int_cnt_d;
            level_cnt_q <= level_cnt_d;
            level_q     <= level_d;
            issued_q    <= issued_d;
            break_req_q <= break_req_d;
            break_hex_q <= break_hex_d;
        end
    end

    assign break_req    = break_req_q;
    assign break_hex    = break_hex_q;
    assign level        = level_q;
    assign issued_count = issued_q;
    assign q_Idle       = (state_q == ST_IDLE);
    assign q_Grace      = (state_q == ST_GRACE);
    assign q_Armed      = (state_q == ST_ARMED);

endmodule

// File: doc/nexys_starship_fault_sched.md
# nexys_starship_fault_sched

Fault scheduler for the starship repair subsystems. It decides when a subsystem breaks, which one breaks, and which hex repair combo goes with the failure. It drives one-hot, one-tick break requests that replace the free-running random triggers each repair FSM currently uses. It runs on timer_clk and tightens the break interval as play continues, up to a fixed floor.

## Interface
Parameters:
- N_SUB, 4: number of repair subsystems (index 0..N_SUB-1); fixed at 4 for this release.
- GRACE_TICKS, 8: ticks after game start before any break is allowed.
- BASE_INTERVAL, 16: ticks between breaks at level 0.
- LEVEL_STEP, 2: interval reduction per level.
- MIN_INTERVAL, 4: interval floor.
- LEVEL_TICKS, 64: ARMED ticks per level increment.
- MAX_BROKEN, 2: maximum simultaneously broken subsystems before scheduling stalls.

Ports:
- timer_clk, in, 1: clock. All logic runs on this clock.
- Reset, in, 1: reset, asynchronous, active-high.
- play_flag, in, 1: game start request (Clk domain, level).
- gameover_ctrl, in, 1: game over (Clk domain, level).
- broken, in, N_SUB: per-subsystem broken status (Clk domain).
- break_req, out, N_SUB: one-hot break pulse, one timer_clk cycle wide.
- break_hex, out, 4: repair combo. Valid while break_req≠0 and held until the next issue.
- level, out, 3: difficulty level, saturating at 7.
- issued_count, out, 8: breaks issued this game, saturating at 255.
- q_Idle, q_Grace, q_Armed, out, 1 each: one-hot state.

## Operation
- play_flag, gameover_ctrl and broken each pass through a 2-flop synchronizer. All logic below uses the synchronized copies.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Reset value 16'hACE1.
  - Steps on every timer_clk edge out of reset, in all states.
  - Candidate index = lfsr[1:0]; hex = lfsr[7:4], both sampled from the pre-step value in the issue cycle.
- IDLE:
  - Outputs cleared except break_hex; level=0, issued_count=0, counters=0.
  - play_flag → GRACE, grace_cnt←GRACE_TICKS.
- GRACE:
  - grace_cnt decrements each tick.
  - When grace_cnt==1 → ARMED, int_cnt←BASE_INTERVAL, level_cnt←0.
- ARMED:
  - int_cnt decrements, holding at 1.
  - Expiry = int_cnt==1 and eligible.
  - Eligible = popcount(broken) < MAX_BROKEN and at least one subsystem not broken.
  - At expiry:
    - Select the candidate. If it is broken, take the next non-broken index upward, wrapping mod N_SUB.
    - Register break_req one-hot and break_hex.
    - issued_count++ (saturating).
    - Reload int_cnt←interval.
  - If expired but not eligible: int_cnt holds at 1 and issue occurs on the first eligible tick.
  - level_cnt increments each ARMED tick. At LEVEL_TICKS-1 it wraps to 0 and level++ (saturating at 7).
  - interval = MIN_INTERVAL if level·LEVEL_STEP ≥ BASE_INTERVAL−MIN_INTERVAL, else BASE_INTERVAL−level·LEVEL_STEP. Compute in 8-bit unsigned with no underflow.
  - The reload uses the level value in effect during the issue tick.
- gameover_ctrl in GRACE or ARMED → IDLE next tick, break_req forced 0. gameover_ctrl has priority over expiry in the same tick.
- play_flag remaining high in ARMED has no effect. After gameover the FSM returns to IDLE. If play_flag is still high there, the next game starts one tick later.
- Unreachable state encodings → IDLE.

## Timing
- Reset values:
  - State IDLE.
  - break_req=0, break_hex=0, level=0, issued_count=0.
  - lfsr=16'hACE1, all counters 0.
  - Synchronizers 0.
- Input-to-state latency: 3 timer_clk edges (2 sync + state register).
- GRACE lasts exactly GRACE_TICKS cycles.
- The first break_req rises exactly BASE_INTERVAL cycles after ARMED entry, provided the block is eligible.
- break_req is high for exactly one cycle. The minimum spacing between pulses is MIN_INTERVAL cycles.
- broken changes affect eligibility 2 cycles later, so the Clk-domain repair FSM must latch break_req across domains itself.

## Test plan
- Reset mid-ARMED: assert Reset asynchronously → all outputs 0 immediately, lfsr=ACE1, q_Idle=1.
- Default params, broken=0, play_flag pulse: q_Grace at edge 3, q_Armed 8 edges later, first break_req 16 edges after ARMED entry. Index and hex must match a reference LFSR model from ACE1.
- Level ramp: stay ARMED 64·7 ticks → level reaches 7 and the break spacing drops 16,14,…,4 and stays 4. level holds at 7.
- Stall: broken=4'b0011 → no break_req while int_cnt sits at 1. Clear broken[0] → break_req issues 3 edges later to index 0, 2 or 3 (never 1).
- Round-robin skip: broken=4'b1000 with candidate 3 → break_req=4'b0001.
- gameover_ctrl asserted in the same synchronized tick as expiry → no pulse, q_Idle next edge, issued_count=0.
